pipe_hazard_ctrl: RTL and testbench

Pipeline control unit for the 16-bit pipelined core. It drives the write-enable and flush controls of the PC, the IF/ID register and the ID/EX register. It resolves load-use hazards, taken-branch flushes and multi-cycle execute operations through a start/done handshake, and it keeps saturating stall and flush performance counters. It sits beside the IF/ID and ID/EX pipeline registers and is the only source of their enable and flush controls.

---
 rtl/pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit for the 16-bit pipelined core.
// It is the only source of the PC, IF/ID and ID/EX enable and flush controls.
// It resolves load-use hazards, taken-branch flushes and multi-cycle execute
// operations, and it keeps saturating stall and flush performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int MC_TIMEOUT  = 64,
  parameter int INIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mc_start,
  input  logic                  mc_done,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_hold,
  output logic                  mc_go,
  output logic                  mc_timeout,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_events
);

  localparam int WaitW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam int InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MC_TIMEOUT - 1);
  localparam logic [InitW-1:0] InitLast = InitW'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    MC_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [InitW-1:0] initCnt_q;
  logic [WaitW-1:0] waitCnt_q;
  logic             timeout_q;
  logic [15:0]      stallCnt_q;
  logic [15:0]      flushCnt_q;

  logic mcStart;
  logic branchTaken;
  logic loadUse;
  logic waitExpired;
  logic branchFlush;

  // Register 0 is hard-wired to zero, so a load into it can never create a hazard.
  assign mcStart     = ex_valid & ex_mc_start;
  assign branchTaken = ex_valid & ex_branch_taken;
  assign loadUse     = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                       ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                        (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign waitExpired = (waitCnt_q == WaitLast);
  assign branchFlush = (state_q == RUN) & ~mcStart & branchTaken;

  assign mc_timeout   = timeout_q;
  assign stall_cycles = stallCnt_q;
  assign flush_events = flushCnt_q;

  // State register; reset always lands in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  // Next-state logic: INIT times out, RUN enters MC_WAIT on a multi-cycle op,
  // and MC_WAIT leaves on done or on the timeout cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (initCnt_q == InitLast) state_d = RUN;
      RUN:     if (mcStart) state_d = MC_WAIT;
      MC_WAIT: if (mc_done || waitExpired) state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Output logic; priority in RUN is multi-cycle start, branch, load-use, normal.
  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    mc_go       = 1'b0;
    case (state_q)
      RUN: begin
        if (mcStart) begin
          mc_go   = 1'b1;
          ex_hold = 1'b1;
        end else if (branchTaken) begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (loadUse) begin
          id_ex_flush = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      MC_WAIT: begin
        if (mc_done || waitExpired) begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end else begin
          ex_hold = 1'b1;
        end
      end
      default: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
    endcase
  end

  // Init counter measures the flush window after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         initCnt_q <= '0;
    else if (state_q == INIT && initCnt_q != InitLast) initCnt_q <= initCnt_q + 1'b1;
  end

  // Wait counter restarts on each multi-cycle start and counts held wait cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      waitCnt_q <= '0;
    else if (state_q == RUN && mcStart)
      waitCnt_q <= '0;
    else if (state_q == MC_WAIT && !mc_done && !waitExpired)
      waitCnt_q <= waitCnt_q + 1'b1;
  end

  // Sticky timeout flag; a done on the final wait cycle wins over the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timeout_q <= 1'b0;
    else if (state_q == MC_WAIT && !mc_done && waitExpired)
      timeout_q <= 1'b1;
  end

  // Stall counter counts every non-INIT cycle in which the PC is frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stallCnt_q <= '0;
    else if (state_q != INIT && !pc_write && stallCnt_q != 16'hFFFF)
      stallCnt_q <= stallCnt_q + 16'd1;
  end

  // Flush counter counts taken-branch flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flushCnt_q <= '0;
    else if (branchFlush && flushCnt_q != 16'hFFFF)
      flushCnt_q <= flushCnt_q + 16'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl.
// dutA uses the default timeout; dutB uses MC_TIMEOUT=4 for the timeout cases.
// Control outputs are compared as {pc_write, if_id_write, if_id_flush,
// id_ex_flush, ex_hold, mc_go}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       idValid, idUsesRs1, idUsesRs2;
  logic [3:0] idRs1, idRs2, exRd;
  logic       exValid, exMemRead, exBranchTaken, exMcStart, mcDone;

  logic        aPcWrite, aIfIdWrite, aIfIdFlush, aIdExFlush, aExHold, aMcGo, aTimeout;
  logic [15:0] aStall, aFlush;
  logic        bPcWrite, bIfIdWrite, bIfIdFlush, bIdExFlush, bExHold, bMcGo, bTimeout;
  logic [15:0] bStall, bFlush;

  logic [5:0] ctlA, ctlB;
  assign ctlA = {aPcWrite, aIfIdWrite, aIfIdFlush, aIdExFlush, aExHold, aMcGo};
  assign ctlB = {bPcWrite, bIfIdWrite, bIfIdFlush, bIdExFlush, bExHold, bMcGo};

  localparam logic [5:0] CtlInit  = 6'b001100;
  localparam logic [5:0] CtlRun   = 6'b110000;
  localparam logic [5:0] CtlLoad  = 6'b000100;
  localparam logic [5:0] CtlBr    = 6'b111100;
  localparam logic [5:0] CtlStart = 6'b000011;
  localparam logic [5:0] CtlHold  = 6'b000010;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(4), .MC_TIMEOUT(64), .INIT_CYCLES(2)) dutA (
    .clk(clk), .reset(reset),
    .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2),
    .ex_valid(exValid), .ex_mem_read(exMemRead), .ex_rd(exRd),
    .ex_branch_taken(exBranchTaken), .ex_mc_start(exMcStart), .mc_done(mcDone),
    .pc_write(aPcWrite), .if_id_write(aIfIdWrite), .if_id_flush(aIfIdFlush),
    .id_ex_flush(aIdExFlush), .ex_hold(aExHold), .mc_go(aMcGo),
    .mc_timeout(aTimeout), .stall_cycles(aStall), .flush_events(aFlush)
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(4), .MC_TIMEOUT(4), .INIT_CYCLES(2)) dutB (
    .clk(clk), .reset(reset),
    .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2),
    .ex_valid(exValid), .ex_mem_read(exMemRead), .ex_rd(exRd),
    .ex_branch_taken(exBranchTaken), .ex_mc_start(exMcStart), .mc_done(mcDone),
    .pc_write(bPcWrite), .if_id_write(bIfIdWrite), .if_id_flush(bIfIdFlush),
    .id_ex_flush(bIdExFlush), .ex_hold(bExHold), .mc_go(bMcGo),
    .mc_timeout(bTimeout), .stall_cycles(bStall), .flush_events(bFlush)
  );

  // Advance to just after the next rising edge.
  task automatic stepClock();
    @(posedge clk);
    #2;
  endtask

  // Drive every DUT input, then let the combinational outputs settle.
  task automatic applyStimulus(input logic idv, input logic [3:0] rs1, input logic [3:0] rs2,
                               input logic u1, input logic u2, input logic exv,
                               input logic mr, input logic [3:0] rd, input logic br,
                               input logic st, input logic done);
    idValid = idv; idRs1 = rs1; idRs2 = rs2; idUsesRs1 = u1; idUsesRs2 = u2;
    exValid = exv; exMemRead = mr; exRd = rd; exBranchTaken = br;
    exMcStart = st; mcDone = done;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset with idle inputs
    reset = 1'b1;
    applyIdle();
    checkOutput("rst_ctlA", {10'd0, ctlA}, {10'd0, CtlInit});
    checkOutput("rst_stall", aStall, 16'd0);
    checkOutput("rst_flush", aFlush, 16'd0);
    stepClock();
    stepClock();
    reset = 1'b0;
    applyIdle();
    checkOutput("init1_ctlA", {10'd0, ctlA}, {10'd0, CtlInit});
    stepClock();
    applyIdle();
    checkOutput("init2_ctlA", {10'd0, ctlA}, {10'd0, CtlInit});
    stepClock();
    applyIdle();
    checkOutput("run_ctlA", {10'd0, ctlA}, {10'd0, CtlRun});
    checkOutput("run_stall0", aStall, 16'd0);
    checkOutput("run_flush0", aFlush, 16'd0);

    // Load-use on rs2
    applyStimulus(1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs2_ctl", {10'd0, ctlA}, {10'd0, CtlLoad});
    stepClock();
    checkOutput("lu_rs2_stall", aStall, 16'd1);
    // ex_rd = 0 matching id_rs2 = 0 must not stall
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_r0_ctl", {10'd0, ctlA}, {10'd0, CtlRun});
    stepClock();
    checkOutput("lu_r0_stall", aStall, 16'd1);
    // Load-use on rs1
    applyStimulus(1'b1, 4'd5, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs1_ctl", {10'd0, ctlA}, {10'd0, CtlLoad});
    stepClock();
    checkOutput("lu_rs1_stall", aStall, 16'd2);
    // Same registers but rs1 not actually read
    applyStimulus(1'b1, 4'd5, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_unused_ctl", {10'd0, ctlA}, {10'd0, CtlRun});
    stepClock();
    // Same match but ID holds no instruction
    applyStimulus(1'b0, 4'd5, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_idinv_ctl", {10'd0, ctlA}, {10'd0, CtlRun});
    stepClock();
    checkOutput("lu_final_stall", aStall, 16'd2);

    // Branch taken beats a simultaneous load-use match
    applyStimulus(1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("br_ctl", {10'd0, ctlA}, {10'd0, CtlBr});
    stepClock();
    checkOutput("br_flush", aFlush, 16'd1);
    checkOutput("br_stall", aStall, 16'd2);

    // Five-cycle multi-cycle op on dutA; start stays high to prove single mc_go
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("mc_start_ctl", {10'd0, ctlA}, {10'd0, CtlStart});
    stepClock();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("mc_wait%0d_ctl", i), {10'd0, ctlA}, {10'd0, CtlHold});
      stepClock();
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("mc_release_ctl", {10'd0, ctlA}, {10'd0, CtlRun});
    stepClock();
    applyIdle();
    checkOutput("mc_run_ctl", {10'd0, ctlA}, {10'd0, CtlRun});
    checkOutput("mc_stall", aStall, 16'd7);
    checkOutput("mc_flush", aFlush, 16'd1);

    // Reset asserted while dutA is in MC_WAIT (dutB has timed out by now)
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    stepClock();
    applyIdle();
    checkOutput("mcw_hold_ctl", {10'd0, ctlA}, {10'd0, CtlHold});
    reset = 1'b1;
    #1;
    checkOutput("mcw_rst_ctl", {10'd0, ctlA}, {10'd0, CtlInit});
    checkOutput("mcw_rst_stall", aStall, 16'd0);
    checkOutput("mcw_rst_flush", aFlush, 16'd0);
    checkOutput("mcw_rst_toB", {15'd0, bTimeout}, 16'd0);
    stepClock();
    reset = 1'b0;
    applyIdle();
    stepClock();
    stepClock();
    applyIdle();
    checkOutput("rerun_ctlB", {10'd0, ctlB}, {10'd0, CtlRun});

    // dutB: done on the final wait cycle is treated as done, no timeout
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("edge_start_ctlB", {10'd0, ctlB}, {10'd0, CtlStart});
    stepClock();
    for (int i = 1; i <= 3; i++) begin
      applyIdle();
      checkOutput($sformatf("edge_wait%0d_ctlB", i), {10'd0, ctlB}, {10'd0, CtlHold});
      stepClock();
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("edge_release_ctlB", {10'd0, ctlB}, {10'd0, CtlRun});
    stepClock();
    applyIdle();
    checkOutput("edge_timeoutB", {15'd0, bTimeout}, 16'd0);
    checkOutput("edge_stallB", bStall, 16'd4);

    // dutB: timeout with mc_done never asserted
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("to_start_ctlB", {10'd0, ctlB}, {10'd0, CtlStart});
    stepClock();
    for (int i = 1; i <= 3; i++) begin
      applyIdle();
      checkOutput($sformatf("to_wait%0d_ctlB", i), {10'd0, ctlB}, {10'd0, CtlHold});
      stepClock();
    end
    applyIdle();
    checkOutput("to_release_ctlB", {10'd0, ctlB}, {10'd0, CtlRun});
    checkOutput("to_notyetB", {15'd0, bTimeout}, 16'd0);
    stepClock();
    applyIdle();
    checkOutput("to_setB", {15'd0, bTimeout}, 16'd1);
    checkOutput("to_runB", {10'd0, ctlB}, {10'd0, CtlRun});
    checkOutput("to_stallB", bStall, 16'd8);

    // dutB: second op completes normally, flag stays set
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("op2_start_ctlB", {10'd0, ctlB}, {10'd0, CtlStart});
    stepClock();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("op2_release_ctlB", {10'd0, ctlB}, {10'd0, CtlRun});
    stepClock();
    applyIdle();
    checkOutput("op2_runB", {10'd0, ctlB}, {10'd0, CtlRun});
    checkOutput("op2_timeoutB", {15'd0, bTimeout}, 16'd1);
    checkOutput("op2_stallB", bStall, 16'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
